// File: rtl/gf2mz_mul_arb_pkg.sv
// Shared types and constants for the two-requester GF(2^m)[z] multiplier arbiter.
package gf2mz_mul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_t;

  localparam logic WR_SEL_A = 1'b0;
  localparam logic WR_SEL_B = 1'b1;

endpackage

// File: rtl/gf2mz_mul_arb_wdog.sv
// Run watchdog: cycle counter cleared outside RUN, flags the cycle in which the
// TIMEOUT-th RUN cycle completes so the abort done lands TIMEOUT cycles after core_start.
module gf2mz_wdog #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAXC = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAXC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/gf2mz_mul_arb.sv
// Round-robin owner arbitration for a shared GF(2^m)[z] multiplier core:
// grants, operand write gating, start/done routing and run watchdog abort.
module gf2mz_mul_arb
  import gf2mz_mul_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 335,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              start0,
  input  logic              start1,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic              wr_sel0,
  input  logic              wr_sel1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [WIDTH-1:0]  wr_data0,
  input  logic [WIDTH-1:0]  wr_data1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic              core_start,
  input  logic              core_done,
  output logic              mem_we_a,
  output logic              mem_we_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data,
  output logic              busy
);

  arb_state_t state_q, state_d;
  logic owner_q, owner_d;
  logic rr_q, rr_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic cstart_q, cstart_d;
  logic abort_q, abort_d;
  logic own_req, own_start, wd_exp;

  assign own_req   = owner_q ? req1   : req0;
  assign own_start = owner_q ? start1 : start0;

  gf2mz_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr_i    (state_q != ST_RUN),
    .en_i     (state_q == ST_RUN),
    .expire_o (wd_exp)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cstart_d = 1'b0;
    abort_d  = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? ~rr_q : req1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!own_req) begin
          state_d = ST_IDLE;
        end else if (own_start) begin
          state_d  = ST_RUN;
          cstart_d = 1'b1;
        end
      end
      ST_RUN: begin
        // An abandoned run still waits for the core, then releases without done.
        if (!own_req) abort_d = 1'b1;
        if (core_done || wd_exp) begin
          if (abort_q || !own_req) begin
            state_d = ST_IDLE;
            rr_d    = owner_q;
          end else begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
            err_d   = !core_done;
          end
        end
      end
      ST_HOLD: begin
        if (!own_req) begin
          state_d = ST_IDLE;
          rr_d    = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cstart_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cstart_q <= cstart_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    mem_we_a = 1'b0;
    mem_we_b = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (state_q == ST_LOAD) begin
      if (owner_q) begin
        mem_we_a = wr_en1 && (wr_sel1 == WR_SEL_A);
        mem_we_b = wr_en1 && (wr_sel1 == WR_SEL_B);
        mem_addr = wr_addr1;
        mem_data = wr_data1;
      end else begin
        mem_we_a = wr_en0 && (wr_sel0 == WR_SEL_A);
        mem_we_b = wr_en0 && (wr_sel0 == WR_SEL_B);
        mem_addr = wr_addr0;
        mem_data = wr_data0;
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign gnt0       = busy && !owner_q;
  assign gnt1       = busy && owner_q;
  assign done0      = done_q && !owner_q;
  assign done1      = done_q && owner_q;
  assign err        = err_q;
  assign core_start = cstart_q;

endmodule
